icache_refill: RTL

- Miss-handling controller for the instruction cache.
- On a fetch miss it issues one AXI4 INCR burst read for the whole line on the master read channel.
- It returns each beat to the cache storage as one write on the cache write port (icache_awaddr/icache_wdata/icache_wvalid). This is the writer end of that port; the cache storage is the reader.
- It sits between the IFU/icache pair and the AXI read channel, and stalls the IFU until the line is installed.

---
 rtl/icache_refill.sv | 116 +++++++++++
 1 files changed

// File: rtl/icache_refill.sv
// Instruction-cache miss handler: one AXI4 INCR line burst per miss, each beat
// forwarded to the cache write port; IFU stalled until the line is installed.
module icache_refill #(
    parameter int ADDR_LEN   = 32,
    parameter int DATA_LEN   = 32,
    parameter int OFFSET_LEN = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [ADDR_LEN-1:0] ifu_araddr,
    input  logic                ifu_arvalid,
    input  logic                icache_hit,
    input  logic                inst_fencei,
    output logic                refill_busy,
    output logic                access_fault,
    output logic [ADDR_LEN-1:0] icache_awaddr,
    output logic [DATA_LEN-1:0] icache_wdata,
    output logic                icache_wvalid,
    output logic                io_master_arvalid,
    input  logic                io_master_arready,
    output logic [ADDR_LEN-1:0] io_master_araddr,
    output logic [7:0]          io_master_arlen,
    output logic [2:0]          io_master_arsize,
    output logic [1:0]          io_master_arburst,
    input  logic                io_master_rvalid,
    output logic                io_master_rready,
    input  logic [DATA_LEN-1:0] io_master_rdata,
    input  logic [1:0]          io_master_rresp,
    input  logic                io_master_rlast
);
    localparam int CNT_W = OFFSET_LEN - 2;
    localparam int BEATS = 1 << CNT_W;
    localparam logic [ADDR_LEN-1:0] OFF_MASK = ADDR_LEN'((1 << OFFSET_LEN) - 1);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [ADDR_LEN-1:0] base_q, base_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                drop_q, drop_d;
    logic                err_q, err_d;
    logic                beat;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            drop_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
        end
    end

    assign beat = (state_q == S_R) && io_master_rvalid;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        drop_d  = drop_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (ifu_arvalid && !icache_hit && !inst_fencei) begin
                    base_d  = ifu_araddr & ~OFF_MASK;
                    cnt_d   = '0;
                    drop_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_AR;
                end
            end
            S_AR: begin
                if (inst_fencei) drop_d = 1'b1;
                if (io_master_arready) state_d = S_R;
            end
            S_R: begin
                if (inst_fencei) drop_d = 1'b1;
                if (io_master_rvalid) begin
                    cnt_d = cnt_q + 1'b1;
                    if (io_master_rresp != 2'b00) err_d = 1'b1;
                    if (io_master_rlast) begin
                        // A burst ending before the final beat left the line incomplete.
                        if (cnt_q != CNT_W'(BEATS - 1)) err_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        refill_busy       = (state_q != S_IDLE);
        access_fault      = (state_q == S_DONE) && err_q;
        io_master_arvalid = (state_q == S_AR);
        io_master_araddr  = (state_q == S_AR) ? base_q : '0;
        io_master_rready  = (state_q == S_R);
        // fence.i on the beat's own cycle already kills that beat.
        icache_wvalid     = beat && !drop_q && !inst_fencei && !err_q &&
                            (io_master_rresp == 2'b00);
        icache_awaddr     = beat ? (base_q | ({{(ADDR_LEN-CNT_W){1'b0}}, cnt_q} << 2)) : '0;
        icache_wdata      = beat ? io_master_rdata : '0;
    end

    assign io_master_arlen   = 8'(BEATS - 1);
    assign io_master_arsize  = 3'b010;
    assign io_master_arburst = 2'b01;

endmodule
